// File: rtl/instr_readback_pkg.sv
// -----------------------------------------------------------------------------
// instr_readback_pkg
// Shared assembler package for the instruction readback path.
//   - NUMBER_LINES / DATA_WIDTH : instruction BRAM geometry shared with the
//                                 assembler write path
//   - PC_WIDTH / ADDR_WIDTH     : byte-PC and word-address widths
//   - rb_state_t                : readback state machine encoding
//   - rb_entry_t                : {pc, word} entry held in the readback FIFO
//   - words_from_end_pc()       : rounds/clamps an end PC into a word count
// Optional feature macro used by the readback top: READBACK_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package instr_readback_pkg;

   localparam int NUMBER_LINES = 256;
   localparam int DATA_WIDTH   = 32;
   localparam int PC_WIDTH     = $clog2(NUMBER_LINES * 4);
   localparam int ADDR_WIDTH   = $clog2(NUMBER_LINES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rb_state_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0] word;
   } rb_entry_t;

   // Drops the byte offset (low two bits) and clamps to the BRAM depth, so a
   // runaway end PC can never make the reader wrap around the address space.
   function automatic logic [ADDR_WIDTH:0] words_from_end_pc(input logic [PC_WIDTH:0] end_pc);
      logic [PC_WIDTH:0] w_raw;
      w_raw = end_pc >> 2;
      if (w_raw > (PC_WIDTH+1)'(NUMBER_LINES))
         return (ADDR_WIDTH+1)'(NUMBER_LINES);
      return w_raw[ADDR_WIDTH:0];
   endfunction

endpackage

// File: rtl/instr_readback_fifo.sv
// -----------------------------------------------------------------------------
// readback_fifo
// Small synchronous FIFO of {pc, word} entries between the BRAM return path
// and the streaming output of instr_readback.
// Ports:
//   clk_in    : clock
//   rst_in    : asynchronous active-high reset (empties the FIFO)
//   push_in   : write data_in this cycle (ignored when full)
//   data_in   : entry to write
//   pop_in    : remove the head entry this cycle (ignored when empty)
//   data_out  : head entry (meaningful only when not empty)
//   full_out  : FIFO holds DEPTH entries
//   empty_out : FIFO holds no entries
//   count_out : current occupancy
// -----------------------------------------------------------------------------
module readback_fifo
   import instr_readback_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         push_in,
   input  rb_entry_t                    data_in,
   input  logic                         pop_in,
   output rb_entry_t                    data_out,
   output logic                         full_out,
   output logic                         empty_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   rb_entry_t      r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_push;
   logic           w_pop;

   assign full_out  = (r_count == CW'(DEPTH));
   assign empty_out = (r_count == '0);
   assign count_out = r_count;
   assign data_out  = r_mem[r_rd_ptr];

   assign w_push = push_in && !full_out;
   assign w_pop  = pop_in && !empty_out;

   // Storage needs no reset: an entry is only ever observed after a push.
   always_ff @(posedge clk_in) begin
      if (w_push)
         r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_readback.sv
// -----------------------------------------------------------------------------
// instr_readback
// Walks the instruction BRAM from word 0 up to end_pc/4-1 and streams every
// word with its byte PC over a valid/ready interface.
// Optional feature: define READBACK_CHECKSUM_EN to add checksum_out, the
// modulo-2^DATA_WIDTH sum of all words handshaken in the current readback.
// Ports:
//   clk_in        : clock
//   rst_in        : asynchronous active-high reset
//   start_in      : begin a readback (sampled in IDLE; a start seen during
//                   the done cycle is remembered and launched from IDLE)
//   end_pc_in     : byte PC one past the last word, sampled with start_in
//   bram_addr_out : BRAM word address
//   bram_en_out   : BRAM read enable, high only on issuing cycles
//   bram_data_in  : BRAM read data, BRAM_LATENCY cycles after the address
//   word_out      : streamed instruction word
//   pc_out        : byte PC of word_out
//   valid_out     : word_out/pc_out valid
//   ready_in      : consumer accepts the current word
//   busy_out      : readback in progress (FETCH or DRAIN)
//   done_out      : one-cycle completion pulse
//   checksum_out  : (READBACK_CHECKSUM_EN only) running word sum
// -----------------------------------------------------------------------------
module instr_readback
   import instr_readback_pkg::*;
#(
   parameter int BRAM_LATENCY = 2
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start_in,
   input  logic [PC_WIDTH:0]       end_pc_in,
   output logic [ADDR_WIDTH-1:0]   bram_addr_out,
   output logic                    bram_en_out,
   input  logic [DATA_WIDTH-1:0]   bram_data_in,
   output logic [DATA_WIDTH-1:0]   word_out,
   output logic [PC_WIDTH-1:0]     pc_out,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic                    busy_out,
   output logic                    done_out
`ifdef READBACK_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]   checksum_out
`endif
);

   // Two spare slots beyond the read latency let the pipeline run at one
   // word per cycle while the head entry is being handed off.
   localparam int DEPTH = BRAM_LATENCY + 2;
   localparam int CW    = $clog2(DEPTH + 1);

   rb_state_t              r_state;
   rb_state_t              w_state_next;
   logic [ADDR_WIDTH:0]    r_num_words;
   logic [ADDR_WIDTH:0]    r_issue_cnt;
   logic [ADDR_WIDTH:0]    r_pop_cnt;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [ADDR_WIDTH-1:0]  r_push_cnt;
   logic                   r_inflight [BRAM_LATENCY];
   logic                   r_start_pend;
   logic [PC_WIDTH:0]      r_end_pc_pend;

   logic                   w_start;
   logic                   w_launch;
   logic [PC_WIDTH:0]      w_end_pc;
   logic [ADDR_WIDTH:0]    w_words;
   logic [ADDR_WIDTH:0]    w_issue_inc;
   logic [ADDR_WIDTH:0]    w_pop_inc;
   logic                   w_issue;
   logic                   w_done;
   logic                   w_push;
   logic                   w_handshake;
   logic [CW-1:0]          w_inflight_cnt;
   logic [CW:0]            w_outstanding;
   logic                   w_credit;
   rb_entry_t              w_push_entry;
   rb_entry_t              w_head;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic [CW-1:0]          w_fifo_count;

   // ---------------------------------------------------------------- launch
   assign w_start     = start_in || r_start_pend;
   assign w_end_pc    = r_start_pend ? r_end_pc_pend : end_pc_in;
   assign w_words     = words_from_end_pc(w_end_pc);
   assign w_launch    = (r_state == IDLE) && w_start;
   assign w_issue_inc = r_issue_cnt + 1'b1;
   assign w_pop_inc   = r_pop_cnt + 1'b1;

   // ---------------------------------------------------------------- credit
   // Every issued read owns a FIFO slot from issue until it is popped, so
   // return data can never find the FIFO full.
   always_comb begin
      w_inflight_cnt = '0;
      for (int i = 0; i < BRAM_LATENCY; i++)
         w_inflight_cnt = w_inflight_cnt + {{(CW-1){1'b0}}, r_inflight[i]};
   end

   assign w_outstanding = {1'b0, w_fifo_count} + {1'b0, w_inflight_cnt};
   assign w_credit      = (w_outstanding < (CW+1)'(DEPTH)) && !w_fifo_full;

   // ---------------------------------------------------------- state machine
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start)
               w_state_next = (w_words == '0) ? DONE : FETCH;
         end
         FETCH: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (w_issue_inc == r_num_words)
                  w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_handshake && (w_pop_inc == r_num_words))
               w_state_next = DONE;
         end
         DONE: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state       <= IDLE;
         r_num_words   <= '0;
         r_issue_cnt   <= '0;
         r_pop_cnt     <= '0;
         r_addr        <= '0;
         r_push_cnt    <= '0;
         r_start_pend  <= 1'b0;
         r_end_pc_pend <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_launch) begin
            r_num_words  <= w_words;
            r_issue_cnt  <= '0;
            r_pop_cnt    <= '0;
            r_addr       <= '0;
            r_push_cnt   <= '0;
            r_start_pend <= 1'b0;
         end
         if (w_issue) begin
            r_issue_cnt <= w_issue_inc;
            // Hold the final address rather than stepping past the last line.
            if (w_issue_inc != r_num_words)
               r_addr <= r_addr + 1'b1;
         end
         if (w_push)
            r_push_cnt <= r_push_cnt + 1'b1;
         if (w_handshake)
            r_pop_cnt <= w_pop_inc;
         if ((r_state == DONE) && start_in) begin
            r_start_pend  <= 1'b1;
            r_end_pc_pend <= end_pc_in;
         end
      end
   end

   // ------------------------------------------------------- in-flight flags
   // Flag k set means a read issued k+1 cycles ago; the oldest stage marks
   // the cycle in which bram_data_in carries that read's data.
   generate
      for (genvar gi = 0; gi < BRAM_LATENCY; gi++) begin : g_inflight
         if (gi == 0) begin : g_head
            always_ff @(posedge clk_in or posedge rst_in) begin
               if (rst_in) r_inflight[gi] <= 1'b0;
               else        r_inflight[gi] <= w_issue;
            end
         end else begin : g_tail
            always_ff @(posedge clk_in or posedge rst_in) begin
               if (rst_in) r_inflight[gi] <= 1'b0;
               else        r_inflight[gi] <= r_inflight[gi-1];
            end
         end
      end
   endgenerate

   assign w_push            = r_inflight[BRAM_LATENCY-1];
   // Reads return in issue order, so the push count is the word index.
   assign w_push_entry.pc   = {r_push_cnt, 2'b00};
   assign w_push_entry.word = bram_data_in;

   readback_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_in   (w_push),
      .data_in   (w_push_entry),
      .pop_in    (w_handshake),
      .data_out  (w_head),
      .full_out  (w_fifo_full),
      .empty_out (w_fifo_empty),
      .count_out (w_fifo_count)
   );

   // --------------------------------------------------------------- outputs
   assign valid_out     = !w_fifo_empty;
   assign w_handshake   = valid_out && ready_in;
   assign word_out      = valid_out ? w_head.word : '0;
   assign pc_out        = valid_out ? w_head.pc   : '0;
   assign bram_addr_out = r_addr;
   assign bram_en_out   = w_issue;
   assign busy_out      = (r_state == FETCH) || (r_state == DRAIN);
   assign done_out      = w_done;

`ifdef READBACK_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_checksum;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         r_checksum <= '0;
      else if (w_launch)
         r_checksum <= '0;
      else if (w_handshake)
         r_checksum <= r_checksum + word_out;
   end

   assign checksum_out = r_checksum;
`else
   // Checksum port and adder are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_readback.sv
module tb_instr_readback;
   import instr_readback_pkg::*;

   localparam int L = 2;

   logic                   clk_in = 1'b0;
   logic                   rst_in;
   logic                   start_in;
   logic [PC_WIDTH:0]      end_pc_in;
   logic [ADDR_WIDTH-1:0]  bram_addr_out;
   logic                   bram_en_out;
   logic [DATA_WIDTH-1:0]  bram_data_in;
   logic [DATA_WIDTH-1:0]  word_out;
   logic [PC_WIDTH-1:0]    pc_out;
   logic                   valid_out;
   logic                   ready_in;
   logic                   busy_out;
   logic                   done_out;
`ifdef READBACK_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]  checksum_out;
`endif

   int checks;
   int errors;

   logic [31:0] mem  [NUMBER_LINES];
   logic [31:0] pipe [L];

   always #5 clk_in = ~clk_in;

   // BRAM model: data for an address presented in cycle C is on the bus in
   // cycle C+L; poison the bus for cycles with no read so stray pushes show.
   always @(posedge clk_in) begin
      pipe[0] <= bram_en_out ? mem[bram_addr_out] : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++)
         pipe[i] <= pipe[i-1];
   end
   assign bram_data_in = pipe[L-1];

   instr_readback #(
      .BRAM_LATENCY (L)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .end_pc_in     (end_pc_in),
      .bram_addr_out (bram_addr_out),
      .bram_en_out   (bram_en_out),
      .bram_data_in  (bram_data_in),
      .word_out      (word_out),
      .pc_out        (pc_out),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .busy_out      (busy_out),
      .done_out      (done_out)
`ifdef READBACK_CHECKSUM_EN
      ,
      .checksum_out  (checksum_out)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_addr"},  64'(bram_addr_out), 0);
      chk({tag, "_en"},    64'(bram_en_out), 0);
      chk({tag, "_word"},  64'(word_out), 0);
      chk({tag, "_pc"},    64'(pc_out), 0);
      chk({tag, "_valid"}, 64'(valid_out), 0);
      chk({tag, "_busy"},  64'(busy_out), 0);
      chk({tag, "_done"},  64'(done_out), 0);
   endtask

   // Runs one readback from a negedge; the model is simply the list of words
   // 0..n-1 of the BRAM image with PC = 4*index.
   task automatic do_readback(input logic [PC_WIDTH:0] end_pc, input bit rand_ready);
      int           n, exp_done, issued, accepted, c;
      int           q_pc[$];
      logic [31:0]  q_word[$];
      bit           done_seen, prev_stall;
      logic [31:0]  prev_word;
      logic [PC_WIDTH-1:0] prev_pc;
`ifdef READBACK_CHECKSUM_EN
      logic [31:0]  sum;
      sum = 0;
`endif
      n = int'(end_pc) / 4;
      if (n > NUMBER_LINES) n = NUMBER_LINES;
      for (int i = 0; i < n; i++) begin
         q_pc.push_back(4 * i);
         q_word.push_back(mem[i]);
`ifdef READBACK_CHECKSUM_EN
         sum = sum + mem[i];
`endif
      end
      exp_done   = rand_ready ? -1 : ((n == 0) ? 0 : n + L + 1);
      issued     = 0;
      accepted   = 0;
      done_seen  = 0;
      prev_stall = 0;
      prev_word  = '0;
      prev_pc    = '0;

      start_in  = 1'b1;
      end_pc_in = end_pc;
      @(negedge clk_in);
      start_in  = 1'b0;
      end_pc_in = PC_WIDTH'($urandom);
      c = 0;
      while (!done_seen && c < 4000) begin
         if (c > 0) @(negedge clk_in);
         ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (c == 0 && n > 0) begin
            chk("first_addr", 64'(bram_addr_out), 0);
            chk("first_en", 64'(bram_en_out), 1);
            chk("first_busy", 64'(busy_out), 1);
         end
         if (c == 0 && n == 0) begin
            chk("empty_en", 64'(bram_en_out), 0);
            chk("empty_busy", 64'(busy_out), 0);
            chk("empty_valid", 64'(valid_out), 0);
         end
         if (prev_stall) begin
            chk("stall_valid", 64'(valid_out), 1);
            chk("stall_word", 64'(word_out), 64'(prev_word));
            chk("stall_pc", 64'(pc_out), 64'(prev_pc));
         end
         if (bram_en_out) begin
            chk("issue_addr", 64'(bram_addr_out), 64'(issued));
            chk("issue_in_range", 64'(issued < n), 1);
            chk("credit", 64'((issued - accepted) < (L + 2)), 1);
            issued++;
         end
         if (valid_out && ready_in) begin
            if (q_pc.size() == 0) begin
               chk("extra_word", 64'(pc_out), 64'hFFFF);
            end else begin
               chk("word_pc", 64'(pc_out), 64'(q_pc.pop_front()));
               chk("word_data", 64'(word_out), 64'(q_word.pop_front()));
            end
            accepted++;
         end
         prev_stall = valid_out && !ready_in;
         prev_word  = word_out;
         prev_pc    = pc_out;
         if (done_out) begin
            done_seen = 1;
            chk("done_busy", 64'(busy_out), 0);
            chk("done_remaining", 64'(q_pc.size()), 0);
            chk("done_count", 64'(accepted), 64'(n));
            if (exp_done >= 0)
               chk("done_cycle", 64'(c), 64'(exp_done));
`ifdef READBACK_CHECKSUM_EN
            chk("checksum", 64'(checksum_out), 64'(sum));
`endif
         end
         c++;
      end
      if (!done_seen)
         chk("timeout", 0, 1);
      $display("readback end_pc=%0d words=%0d accepted=%0d cycles=%0d", end_pc, n, accepted, c);
      @(negedge clk_in);
      #1;
      chk("done_pulse", 64'(done_out), 0);
      chk("idle_busy", 64'(busy_out), 0);
      chk("idle_valid", 64'(valid_out), 0);
`ifdef READBACK_CHECKSUM_EN
      chk("checksum_hold", 64'(checksum_out), 64'(sum));
`endif
   endtask

   initial begin
      int  hs, c;
      bit  bad_done, bad_valid;
      checks    = 0;
      errors    = 0;
      rst_in    = 1'b1;
      start_in  = 1'b0;
      end_pc_in = '0;
      ready_in  = 1'b0;
      for (int i = 0; i < NUMBER_LINES; i++) mem[i] = $urandom;

      // Reset values
      repeat (2) @(negedge clk_in);
      #1;
      check_all_zero("reset");
      @(negedge clk_in);
      rst_in = 1'b0;

      // Four known words, ready always high, exact timing
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
      do_readback(16, 0);
      // Empty program
      do_readback(0, 0);
      // Ten words with random back-pressure
      for (int i = 0; i < 10; i++) mem[i] = $urandom;
      do_readback(40, 1);
      // Oversized end PC: clamped and rounded down
      do_readback(11'h7FF, 0);
      // A few random lengths with back-pressure (low bits exercise rounding)
      for (int k = 0; k < 3; k++)
         do_readback(PC_WIDTH'($urandom_range(1, 200)), 1);

      // Reset in the middle of a readback
      start_in  = 1'b1;
      end_pc_in = 40;
      ready_in  = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      hs = 0;
      c  = 0;
      while (hs < 3 && c < 50) begin
         #1;
         if (valid_out && ready_in) hs++;
         @(negedge clk_in);
         c++;
      end
      #1;
      chk("midrst_busy_before", 64'(busy_out), 1);
      #1;
      rst_in = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk_in);
      rst_in    = 1'b0;
      bad_done  = 0;
      bad_valid = 0;
      repeat (6) begin
         @(negedge clk_in);
         #1;
         if (done_out) bad_done = 1;
         if (valid_out) bad_valid = 1;
      end
      chk("midrst_no_done", 64'(bad_done), 0);
      chk("midrst_no_valid", 64'(bad_valid), 0);
      $display("mid-readback reset after %0d words", hs);
      do_readback(8, 0);

`ifdef READBACK_CHECKSUM_EN
      mem[0] = 32'd1;
      mem[1] = 32'd2;
      mem[2] = 32'd3;
      mem[3] = 32'hFFFF_FFFF;
      do_readback(16, 0);
      chk("checksum_five", 64'(checksum_out), 5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a wait above ever stalls the run.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instr_readback.md
# instr_readback

Reads assembled machine-code words back out of the instruction BRAM that the assembler fills. It is the reader counterpart to the write path, which advances a byte PC by 4 per emitted instruction. Given the final PC reached by the assembler, it walks addresses 0 to end_pc−4, absorbs BRAM read latency, and streams each word with its PC over a valid/ready interface. Downstream consumers are the UART dump and the display/debug path.

## Interface
- NUMBER_LINES, 256: instruction BRAM depth in 32-bit words.
- BRAM_LATENCY, 2: cycles from address presented to data valid on bram_data_in; range 1–3.
- DATA_WIDTH, 32: instruction word width.
- clk_in  input  1  the single clock.
- rst_in  input  1  reset; asynchronous, active-high.
- start_in  input  1  begin a readback; sampled only in IDLE.
- end_pc_in  input  $clog2(NUMBER_LINES*4)+1  byte PC one past the last assembled word; sampled with start_in.
- bram_addr_out  output  $clog2(NUMBER_LINES)  word address to the BRAM.
- bram_en_out  output  1  read enable; high only on cycles that issue a read.
- bram_data_in  input  DATA_WIDTH  BRAM read data.
- word_out  output  DATA_WIDTH  streamed instruction word.
- pc_out  output  $clog2(NUMBER_LINES*4)  byte PC of word_out; low two bits are always 0.
- valid_out  output  1  word_out and pc_out are valid.
- ready_in  input  1  the consumer accepts the word this cycle.
- busy_out  output  1  a readback is in progress.
- done_out  output  1  one-cycle pulse when the readback completes.

## Operation
- States:
  - IDLE: waits for start_in.
  - FETCH: issues reads.
  - DRAIN: all reads issued; waits for the FIFO and in-flight reads to empty.
  - DONE: one cycle; pulses done_out, then returns to IDLE.
- end_pc_in handling:
  - The low two bits are ignored; the value is rounded down to a multiple of 4.
  - Values above NUMBER_LINES*4 are clamped to NUMBER_LINES*4.
  - The word count is end_pc/4.
- start_in with end_pc 0: IDLE → DONE directly. No reads are issued and no words are streamed.
- Reads are issued in FETCH at word addresses 0, 1, 2, … in order.
- Credit rule: a read issues only when FIFO occupancy plus in-flight reads is less than the FIFO depth (BRAM_LATENCY+2). No returned data is ever dropped.
- In-flight tracking: a BRAM_LATENCY-deep shift register of issue flags. When a flag emerges, bram_data_in is pushed into the FIFO together with its PC.
- Output side: the FIFO head drives word_out, pc_out and valid_out. A handshake (valid_out && ready_in) pops the FIFO.
- While valid_out is high and ready_in is low, word_out and pc_out hold stable.
- FETCH → DRAIN when the last address issues. DRAIN → DONE on the handshake of the last word.
- start_in is ignored while busy_out is high.
- Reset values: state IDLE, FIFO empty, in-flight flags clear, and every output 0 (bram_addr_out, bram_en_out, word_out, pc_out, valid_out, busy_out, done_out).
- Reset mid-readback: returns asynchronously to IDLE and discards FIFO contents and in-flight data. No done_out pulse is produced.

## Timing
- start_in sampled at edge E0: in the cycle after E0, bram_addr_out=0 and bram_en_out=1, and busy_out is high.
- Word return: data issued in cycle C is pushed at edge C+BRAM_LATENCY. valid_out is high in the following cycle.
- With ready_in held high:
  - first valid_out occurs BRAM_LATENCY+1 cycles after E0;
  - throughput is one word per cycle;
  - an N-word readback completes with done_out high N+BRAM_LATENCY+1 cycles after E0.
- done_out is high for exactly one cycle, the cycle after the final handshake. busy_out is low in that same cycle.
- A start_in arriving in the done_out cycle is accepted; the state machine is in IDLE on the next edge.
- Full PC space, end_pc=NUMBER_LINES*4:
  - the last word address is NUMBER_LINES−1 and the last pc_out is NUMBER_LINES*4−4;
  - no address wrap occurs.

## Configuration
- READBACK_CHECKSUM_EN defined:
  - adds output checksum_out [DATA_WIDTH-1:0];
  - the checksum is the modulo-2^DATA_WIDTH sum of every handshaken word in the current readback;
  - it clears on an accepted start_in, is valid and stable from the done_out cycle until the next start, and resets to 0.
- READBACK_CHECKSUM_EN undefined: the port and its adder are absent. All other behaviour is identical.

## Structure
- Shared assembler package holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - PC_WIDTH and ADDR_WIDTH derived from NUMBER_LINES;
  - a typedef for the {pc, word} FIFO entry.
- One sub-module, readback_fifo:
  - synchronous FIFO of depth BRAM_LATENCY+2;
  - push/pop/full/empty plus an occupancy count;
  - asynchronous active-high reset.
- Credit logic, the in-flight shift register and the state machine live in instr_readback.

## Test plan
- end_pc_in=16, ready_in always 1, BRAM preloaded with words 0xA0..0xA3 → four handshakes, PCs 0/4/8/12 in order, done_out in cycle E0+7 (BRAM_LATENCY=2).
- end_pc_in=0 → no bram_en_out, no valid_out, done_out one cycle after start, busy_out never high beyond that cycle.
- end_pc_in=40 with ready_in toggling 1-0-0-1 randomly → all 10 words delivered exactly once in order, stable while stalled, FIFO never overflows.
- end_pc_in=0x7FF (NUMBER_LINES=256) → clamped to 1024, rounded; 256 words, last pc_out=1020, no wrap.
- rst_in asserted mid-FETCH after 3 words → outputs 0 immediately, no done_out; a subsequent start_in with end_pc_in=8 streams PCs 0 and 4.
- READBACK_CHECKSUM_EN defined, words 1,2,3,0xFFFFFFFF → checksum_out=5 at done_out.
